// File: rtl/keccak_lane_gearbox.sv
// Re-packs 25 sequential 64-bit Keccak lanes into 16 sequential 100-bit chunks
// (LSB-first) for the chunked Keccak-f wrapper, with framing error detection.
module keccak_lane_gearbox (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [63:0] lane_i,
  input  logic        lane_valid_i,
  input  logic        lane_last_i,
  output logic        lane_ready_o,
  output logic [99:0] chunk_o,
  output logic        chunk_en_o,
  output logic        frame_done_o,
  output logic        err_o
);

  localparam int unsigned BufW  = 164;
  localparam int unsigned ChunkW = 100;

  logic [BufW-1:0] buf_q, buf_d, buf_shift;
  logic [7:0]      fill_q, fill_d, fill_post;
  logic [4:0]      lane_idx_q, lane_idx_d;
  logic [3:0]      chunk_idx_q, chunk_idx_d;
  logic            tail_q, tail_d;
  logic [99:0]     chunk_d;
  logic            chunk_en_d, frame_done_d, err_d;
  logic            emit, accept, last_lane;

  assign lane_ready_o = !tail_q;

  always_comb begin
    emit      = (fill_q >= 8'd100);
    accept    = lane_valid_i && !tail_q;
    last_lane = (lane_idx_q == 5'd24);
    buf_shift = emit ? (buf_q >> ChunkW) : buf_q;
    fill_post = emit ? (fill_q - 8'd100) : fill_q;

    buf_d        = buf_shift;
    fill_d       = fill_post;
    lane_idx_d   = lane_idx_q;
    chunk_idx_d  = chunk_idx_q;
    tail_d       = tail_q;
    chunk_d      = emit ? buf_q[99:0] : chunk_o;
    chunk_en_d   = emit;
    frame_done_d = emit && (chunk_idx_q == 4'd15);
    err_d        = err_o;

    if (emit) begin
      if (chunk_idx_q == 4'd15) begin
        chunk_idx_d = '0;
        tail_d      = 1'b0;
      end else begin
        chunk_idx_d = chunk_idx_q + 4'd1;
      end
    end

    // Bits above fill are always zero, so the new lane can be OR-ed in place.
    if (accept) begin
      buf_d  = buf_shift | ({100'b0, lane_i} << fill_post);
      fill_d = fill_post + 8'd64;
      if (last_lane) begin
        lane_idx_d = '0;
        tail_d     = 1'b1;
      end else begin
        lane_idx_d = lane_idx_q + 5'd1;
      end
      if (lane_last_i != last_lane) err_d = 1'b1;
    end

    if (clear_i) begin
      buf_d        = '0;
      fill_d       = '0;
      lane_idx_d   = '0;
      chunk_idx_d  = '0;
      tail_d       = 1'b0;
      chunk_d      = chunk_o;
      chunk_en_d   = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      fill_q       <= '0;
      lane_idx_q   <= '0;
      chunk_idx_q  <= '0;
      tail_q       <= 1'b0;
      chunk_o      <= '0;
      chunk_en_o   <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      lane_idx_q   <= lane_idx_d;
      chunk_idx_q  <= chunk_idx_d;
      tail_q       <= tail_d;
      chunk_o      <= chunk_d;
      chunk_en_o   <= chunk_en_d;
      frame_done_o <= frame_done_d;
      err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_keccak_lane_gearbox.sv
// Randomized bench for keccak_lane_gearbox against a bit-count stream model.
module tb_keccak_lane_gearbox;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic [63:0] lane_i = '0;
  logic        lane_valid_i = 1'b0;
  logic        lane_last_i = 1'b0;
  logic        lane_ready_o;
  logic [99:0] chunk_o;
  logic        chunk_en_o;
  logic        frame_done_o;
  logic        err_o;

  keccak_lane_gearbox dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .lane_i       (lane_i),
    .lane_valid_i (lane_valid_i),
    .lane_last_i  (lane_last_i),
    .lane_ready_o (lane_ready_o),
    .chunk_o      (chunk_o),
    .chunk_en_o   (chunk_en_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: frame as a 1600-bit vector, tracked by bits accepted and bits emitted.
  int            m_acc = 0;
  int            m_emit = 0;
  logic [1599:0] m_frame = '0;
  logic          m_err = 1'b0;
  logic [99:0]   e_chunk = '0;
  logic          e_en = 1'b0;
  logic          e_done = 1'b0;
  bit            acc, emit;
  int            cyc = 0;
  int            first_edge = 0;
  int            strobe_cnt = 0;
  int            done_cnt = 0;
  int            strobe_off[$];

  initial forever begin
    @(posedge clk_i);
    cyc++;
    if (!rst_ni) begin
      m_acc = 0; m_emit = 0; m_err = 1'b0;
      e_chunk = '0; e_en = 1'b0; e_done = 1'b0;
    end else if (clear_i) begin
      m_acc = 0; m_emit = 0; e_en = 1'b0; e_done = 1'b0;
    end else begin
      acc  = lane_valid_i && (m_acc < 1600);
      emit = (m_acc - m_emit) >= 100;
      e_en = emit;
      e_done = 1'b0;
      if (emit) begin
        e_chunk = m_frame[m_emit +: 100];
        m_emit += 100;
      end
      if (acc) begin
        if (m_acc == 0) first_edge = cyc;
        if (lane_last_i != (m_acc == 1536)) m_err = 1'b1;
        m_frame[m_acc +: 64] = lane_i;
        m_acc += 64;
      end
      if (m_emit == 1600) begin
        e_done = 1'b1;
        m_acc = 0;
        m_emit = 0;
      end
    end
    #1;
    chk("chunk_en", chunk_en_o, e_en);
    chk("frame_done", frame_done_o, e_done);
    chk("err", err_o, m_err);
    chk("lane_ready", lane_ready_o, m_acc < 1600);
    chk("chunk", chunk_o, e_chunk);
    if (chunk_en_o) begin
      strobe_cnt++;
      strobe_off.push_back(cyc - first_edge);
    end
    if (frame_done_o) done_cnt++;
  end

  logic [63:0] lanes [25];

  task automatic rand_lanes();
    for (int j = 0; j < 25; j++) lanes[j] = {$urandom, $urandom};
  endtask

  task automatic drive_lanes(input int n, input int gap_pct, input int last_a, input int last_b);
    for (int j = 0; j < n; j++) begin
      int w = 0;
      bit sent = 1'b0;
      while (!sent) begin
        @(negedge clk_i);
        if (w > 300) begin
          chk("lane_accept_timeout", 1'b1, 1'b0);
          lane_valid_i = 1'b0;
          return;
        end
        w++;
        if ($urandom_range(99) < gap_pct) begin
          lane_valid_i = 1'b0;
          lane_last_i  = 1'b0;
        end else begin
          lane_valid_i = 1'b1;
          lane_i       = lanes[j];
          lane_last_i  = (j == last_a) || (j == last_b);
          sent         = lane_ready_o;
        end
      end
    end
    @(negedge clk_i);
    lane_valid_i = 1'b0;
    lane_last_i  = 1'b0;
  endtask

  int exp_off [16] = '{2, 4, 5, 7, 8, 10, 11, 13, 15, 16, 18, 19, 21, 22, 24, 25};
  int saved;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_chunk_en", chunk_en_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    #1 chk("rst_ready", lane_ready_o, 1'b1);

    // Back-to-back patterned frame with timing check
    for (int j = 0; j < 25; j++) lanes[j] = {32'hA5A5_0000 | j, 32'h0000_0000 | j};
    strobe_cnt = 0; done_cnt = 0; strobe_off.delete();
    drive_lanes(25, 0, 24, -1);
    repeat (4) @(negedge clk_i);
    chk("b2b_strobes", strobe_cnt, 16);
    chk("b2b_done", done_cnt, 1);
    chk("b2b_err", err_o, 1'b0);
    for (int k = 0; k < 16; k++)
      if (k < strobe_off.size()) chk("b2b_strobe_edge", strobe_off[k], exp_off[k]);

    // Two frames with random idle cycles
    strobe_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      rand_lanes();
      drive_lanes(25, 30, 24, -1);
    end
    repeat (4) @(negedge clk_i);
    chk("gap_strobes", strobe_cnt, 32);
    chk("gap_done", done_cnt, 2);

    // Framing errors: early last, then missing last
    rand_lanes();
    drive_lanes(25, 10, 7, 24);
    rand_lanes();
    drive_lanes(25, 0, -1, -1);
    repeat (4) @(negedge clk_i);
    chk("frame_err_sticky", err_o, 1'b1);

    // clear_i mid-frame with a lane presented in the same cycle
    rand_lanes();
    drive_lanes(13, 0, -1, -1);
    @(negedge clk_i);
    clear_i = 1'b1; lane_valid_i = 1'b1; lane_i = {$urandom, $urandom};
    @(negedge clk_i);
    clear_i = 1'b0; lane_valid_i = 1'b0;
    saved = strobe_cnt;
    repeat (5) @(negedge clk_i);
    chk("clear_no_strobe", strobe_cnt, saved);
    strobe_cnt = 0; done_cnt = 0;
    rand_lanes();
    drive_lanes(25, 20, 24, -1);
    repeat (4) @(negedge clk_i);
    chk("clear_strobes", strobe_cnt, 16);
    chk("clear_done", done_cnt, 1);

    // Asynchronous reset mid-frame
    rand_lanes();
    drive_lanes(10, 0, -1, -1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_chunk_en", chunk_en_o, 1'b0);
    chk("arst_done", frame_done_o, 1'b0);
    chk("arst_err", err_o, 1'b0);
    chk("arst_chunk", chunk_o, 100'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 chk("arst_ready", lane_ready_o, 1'b1);
    strobe_cnt = 0; done_cnt = 0;
    rand_lanes();
    drive_lanes(25, 0, 24, -1);
    repeat (4) @(negedge clk_i);
    chk("arst_strobes", strobe_cnt, 16);
    chk("arst_done_cnt", done_cnt, 1);
    chk("arst_err_after", err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
